xcore_mux4_arbiter: RTL



---
 rtl/xcore_pkg.sv | 20 ++
 rtl/xcore_rr_pick.sv | 30 +++
 rtl/xcore_mux4_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/xcore_pkg.sv
// rtl/xcore_pkg.sv - shared types and constants for the xcore_mux4 arbiter
package xcore_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [1:0] SEL_SIG0 = 2'b00;
   localparam logic [1:0] SEL_SIG1 = 2'b01;
   localparam logic [1:0] SEL_SIG2 = 2'b10;
   localparam logic [1:0] SEL_SIG3 = 2'b11;

   localparam int MAX_HOLD_DEF = 8;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/xcore_rr_pick.sv
// rtl/xcore_rr_pick.sv - combinational circular first-request search from a pointer
module xcore_rr_pick
   import xcore_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   input  logic [3:0] excl,
   output logic [1:0] win,
   output logic       found
);

   logic [3:0] masked;
   logic [1:0] idx;

   assign masked = req & ~excl;

   always_comb begin
      win   = SEL_SIG0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && masked[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xcore_mux4_arbiter.sv
// rtl/xcore_mux4_arbiter.sv - round-robin arbiter driving the xcore_mux4 select pair
module xcore_mux4_arbiter
   import xcore_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       scl,
   output logic       dir_en,
   output logic       sel_valid,
   output logic       rotate
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_nxt;
   logic [1:0]       sel, sel_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic             rot_nxt;
   logic [3:0]       grant_nxt;
   logic             valid_nxt;

   logic [1:0]       pick_ptr;
   logic [3:0]       pick_excl;
   logic [1:0]       pick_win;
   logic             pick_found;

   xcore_rr_pick u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .excl  (pick_excl),
      .win   (pick_win),
      .found (pick_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= SEL_SIG0;
         ptr       <= 2'd0;
         hold_cnt  <= '0;
         grant     <= 4'b0000;
         sel_valid <= 1'b0;
         rotate    <= 1'b0;
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
         grant     <= grant_nxt;
         sel_valid <= valid_nxt;
         rotate    <= rot_nxt;
      end
   end

   // The single picker searches from ptr when idle, and from owner+1 excluding the owner otherwise.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      rot_nxt   = 1'b0;
      pick_ptr  = ptr;
      pick_excl = 4'b0000;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               sel_nxt   = pick_win;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            pick_ptr  = sel + 2'd1;
            pick_excl = onehot4(sel);
            if (!req[sel]) begin
               ptr_nxt  = sel + 2'd1;
               hold_nxt = '0;
               if (pick_found) begin
                  sel_nxt = pick_win;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (hold_cnt == HOLD_LAST) begin
               if (pick_found) begin
                  ptr_nxt  = sel + 2'd1;
                  sel_nxt  = pick_win;
                  hold_nxt = '0;
                  rot_nxt  = 1'b1;
               end
            end else begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_nxt = 4'b0000;
      valid_nxt = 1'b0;
      if (state_nxt == GRANT) begin
         grant_nxt = onehot4(sel_nxt);
         valid_nxt = 1'b1;
      end
   end

   assign scl    = sel[1];
   assign dir_en = sel[0];

endmodule
